// File: rtl/core_general.sv
// core_general: shared core widths and load/store byte-enable encodings
package core_general;
  localparam int XLEN = 32;
  localparam int AWIDTH = 32;
  localparam int DWIDTH = XLEN;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/ram_bank.sv
// ram_bank: synchronous single-port word RAM with per-byte write enables and read-first output register
module ram_bank #(
  parameter int DEPTH = 1024,
  parameter int DWIDTH = 32,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IW-1:0]       addr,
  input  logic [DWIDTH/8-1:0] we,
  input  logic [DWIDTH-1:0]   d,
  output logic [DWIDTH-1:0]   q
);
  logic [DWIDTH-1:0] RAM [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else begin
      for (int k = 0; k < DWIDTH/8; k++)
        if (we[k]) RAM[addr][8*k +: 8] <= d[8*k +: 8];
      q <= RAM[addr];
    end
  end
endmodule

// File: rtl/ram.sv
// ram: 4 KiB byte-addressable data memory with lane steering and registered, lane-0 aligned reads
module ram #(
  parameter int AWIDTH = core_general::AWIDTH,
  parameter int DWIDTH = core_general::DWIDTH,
  parameter int DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] qin,
  input  logic [3:0]        we,
  output logic [DWIDTH-1:0] qout
);
  localparam int IW = $clog2(DEPTH);
  logic [1:0] off, off_q;
  logic [3:0] ewe;
  logic [DWIDTH-1:0] edata, word;
  logic unused_hi;
  assign off = addr[1:0];
  assign ewe = we << off;
  assign edata = qin << {off, 3'b000};
  assign unused_hi = ^addr[AWIDTH-1:IW+2];
  // offset travels with the read so the output shift matches the registered word
  always_ff @(posedge clk) off_q <= rst ? 2'b00 : off;
  ram_bank #(.DEPTH(DEPTH), .DWIDTH(DWIDTH)) U_ram (
    .clk(clk),
    .rst(rst),
    .addr(addr[IW+1:2]),
    .we(ewe),
    .d(edata),
    .q(word)
  );
  assign qout = word >> {off_q, 3'b000};
endmodule

// File: tb/tb_ram.sv
// tb_ram: randomized and directed checks of ram against a byte-array reference model
module tb_ram;
  import core_general::*;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] addr, qin, qout, exp;
  logic [3:0] we;
  logic [7:0] mem [4096];
  int checks = 0;
  int failures = 0;
  ram dut (.clk(clk), .rst(rst), .addr(addr), .qin(qin), .we(we), .qout(qout));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r = '0;
    int base = int'(a[11:0]);
    for (int k = 0; k < 4; k++)
      if (base % 4 + k < 4) r[8*k +: 8] = mem[base + k];
    return r;
  endfunction
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    int base = int'(a[11:0]);
    for (int k = 0; k < 4; k++)
      if (w[k] && base % 4 + k < 4) mem[base + k] = d[8*k +: 8];
  endtask
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic r);
    @(negedge clk);
    addr = a; qin = d; we = w; rst = r;
    exp = r ? 32'h0 : model_read(a);
    if (!r) model_write(a, d, w);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] a, d;
    logic [3:0] w;
    logic r;
    addr = '0; qin = '0; we = '0; rst = 1'b1;
    cyc(32'h0, 32'h0, BE_WORD, 1'b1);
    cyc(32'h4, 32'hFFFF_FFFF, BE_WORD, 1'b1);
    chk("reset_qout", qout, 32'h0);
    for (int i = 0; i < 4096; i += 4) begin
      d = {4{i[7:0]}};
      cyc(i, d, BE_WORD, 1'b0);
      cyc(i, 32'h0, 4'b0000, 1'b0);
      chk("word", qout, exp);
      if (i == 'h104) chk("word_104", qout, 32'h0404_0404);
    end
    cyc(32'h102, 32'h0000_0102, BE_HALF, 1'b0);
    cyc(32'h100, 32'h0, 4'b0000, 1'b0);
    chk("half_hi", qout, 32'h0102_0000);
    cyc(32'h102, 32'h0, 4'b0000, 1'b0);
    chk("half_off2", qout, 32'h0000_0102);
    cyc(32'h100, 32'h0000_0100, BE_HALF, 1'b0);
    cyc(32'h100, 32'h0, 4'b0000, 1'b0);
    chk("half_fill", qout, 32'h0102_0100);
    cyc(32'h100, 32'h0000_0100, 4'b1100, 1'b0);
    cyc(32'h100, 32'h0, 4'b0000, 1'b0);
    chk("half_upper_clear", qout, 32'h0000_0100);
    cyc(32'h102, 32'hFFFF_FFFF, 4'b1100, 1'b0);
    cyc(32'h100, 32'h0, 4'b0000, 1'b0);
    chk("half_upper_drop", qout, 32'h0000_0100);
    for (int i = 0; i < 4096; i++) begin
      cyc(i, i, BE_BYTE, 1'b0);
      cyc(i, 32'h0, 4'b0000, 1'b0);
      chk("byte", qout, exp);
      chk("byte_lo", {24'h0, qout[7:0]}, {24'h0, i[7:0]});
      cyc(i, i << 8, 4'b0010, 1'b0);
      cyc(i & ~3, 32'h0, 4'b0000, 1'b0);
      chk("byte_lane1", qout, exp);
      if (i % 4 == 3) begin
        cyc((i + 1) % 4096, 32'h0, 4'b0000, 1'b0);
        chk("byte_nospill", qout, exp);
      end
    end
    cyc(32'h20, 32'hAABB_CCDD, BE_WORD, 1'b0);
    chk("read_first_old", qout, exp);
    cyc(32'h20, 32'h0, 4'b0000, 1'b0);
    chk("read_first_new", qout, 32'hAABB_CCDD);
    cyc(32'h20, 32'h1122_3344, BE_WORD, 1'b1);
    chk("rst_qout", qout, 32'h0);
    chk("rst_mem", dut.U_ram.RAM[8], 32'hAABB_CCDD);
    cyc(32'h20, 32'h0, 4'b0000, 1'b0);
    chk("rst_resume", qout, 32'hAABB_CCDD);
    for (int n = 0; n < 3000; n++) begin
      a = $urandom;
      d = $urandom;
      case ($urandom_range(0, 5))
        0: w = BE_BYTE;
        1: w = BE_HALF;
        2: w = BE_WORD;
        3: w = 4'b0000;
        default: w = 4'($urandom);
      endcase
      r = ($urandom_range(0, 49) == 0);
      cyc(a, d, w, r);
      chk(r ? "rand_rst" : "rand", qout, exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram.md
Name: ram

Overview:
- Core data memory: 4 KiB organised as 1024 x 32-bit words, byte-addressable, byte-enabled writes, registered read.
- Sits in the MemoryAccess stage of the core and serves load/store traffic.
- Byte lanes are steered by the low address bits, so byte, halfword and word accesses all use the same lane-0-aligned data bus.

Parameters:
- AWIDTH, 32, address bus width; comes from the shared core package.
- DWIDTH, 32, data bus width; equal to XLEN.
- DEPTH, 1024, number of 32-bit words (4096 bytes).

Ports:
- clk  input  1  system clock; all activity is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- addr  input  AWIDTH  byte address.
- qin  input  DWIDTH  write data, lane-0 aligned (byte in [7:0], halfword in [15:0]).
- we  input  4  write byte enables, relative to addr (0001 byte, 0011 halfword, 1111 word).
- qout  output  DWIDTH  read data, lane-0 aligned.

Behaviour:
- Word index is addr[11:2]. Byte offset is off = addr[1:0]. addr[AWIDTH-1:12] is ignored, so accesses wrap modulo 4096.
- Write, on a clk rising edge when rst=0:
  - Effective enable: ewe = (we << off), truncated to 4 bits.
  - Effective data: edata = qin << (8*off).
  - For each lane k with ewe[k]=1, byte k of the word receives edata[8k+7:8k].
  - Enables shifted past lane 3 are discarded. There is no spill into the next word and no error flag.
  - we=0000 performs no write.
- Read, registered with one-cycle latency:
  - At each rising edge, qout <= word[addr[11:2]] >> (8*off), zero-filled in the upper bits.
  - The data is valid in the cycle after addr is presented.
  - Reads happen every cycle; there is no read enable.
- Read-during-write to the same word is read-first: qout shows the pre-write contents; new data is visible one cycle later.
- Reset:
  - While rst=1 at a rising edge, qout <= 0 and writes are suppressed.
  - Memory contents are not cleared; power-up contents are undefined (X in simulation).
  - Deasserting rst resumes normal operation at the next edge.
- No handshake: every cycle is a valid access.
- qout is always driven.

Decomposition:
- Shared package (core_general): AWIDTH, DWIDTH, XLEN, and the byte-enable encodings BE_BYTE=0001, BE_HALF=0011, BE_WORD=1111.
- Top ram: lane steering (shift of we/qin by addr[1:0]) and the read-alignment shift.
- Sub-module ram_bank, instance name U_ram: a 1024x32 synchronous single-port RAM with 4 per-byte write enables.
  - Array named RAM, so the bench can probe U_ram.RAM[n].
  - Output register lives here; inference-friendly for block RAM.

Test Plan:
- Word: for every i=0,4,...,4092, write qin={4{i[7:0]}} with we=1111, then read addr=i -> qout after 1 cycle = {4{i[7:0]}` (e.g. i=0x104 -> 0x04040404).
- Halfword: write addr=0x102, qin=0x00000102, we=0011 -> bytes 0x102=0x02, 0x103=0x01. Read addr=0x100 -> qout[31:16]=0x0102. Read addr=0x102 -> qout=0x00000102.
- Halfword upper lanes: with the word at 0x100 holding 0x01020100, write addr=0x100, qin=0x00000100, we=1100 -> bytes 2,3 cleared. Read 0x100 -> 0x00000100. A write at addr=0x102 with we=1100 changes nothing.
- Byte: for every i, write addr=i, qin=i, we=0001; read addr=i -> qout[7:0]=i[7:0]. Then write addr=i, qin=i<<8, we=0010 -> byte i+1 is set for off<3; at off=3 the write is dropped and word w+1 is unmodified.
- Read-first / latency: write 0xAABBCCDD to 0x20 with we=1111 while reading 0x20 -> qout shows the old value that cycle and 0xAABBCCDD the next.
- Reset: assert rst=1 mid-write with we=1111 -> qout=0 and memory unchanged. After deassert, read returns the prior contents.
